// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 matrix keypad scanner.
//   state_t    - scanner FSM state encoding
//   ROWS_IDLE  - row pattern with no key closed (rows are active-low)
//   KEYMAP     - hex code per key, indexed by {row, col}
//   single_low - true when exactly one row line is pulled low
//   low_index  - row number of the single low line
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // Element {r,c}; listed from {3,3} down to {0,0}.
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic single_low(input logic [3:0] rows);
        logic ok;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick.sv
// keypad_tick: free-running scan-rate divider.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   tick  - high for one cycle out of every SCAN_DIV (count 0..SCAN_DIV-1)
module keypad_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce.
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   row_n     - keypad rows, active-low, asynchronous to clk
//   col_n     - column drive, active-low, one column low at a time
//   key_code  - hex code of the last accepted key
//   key_valid - one-cycle pulse per accepted press
//   key_held  - high from press acceptance until release acceptance
//
// state       | meaning
// ST_SCAN     | rotating columns, looking for a single closed row
// ST_DEBOUNCE | column frozen, counting stable ticks of the candidate key
// ST_HELD     | key accepted, waiting for the rows to go idle
// ST_RELEASE  | counting idle ticks before declaring the key released
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    // Acceptance fires on the tick that would bring the count to
    // DEBOUNCE_SCANS, so the counter never has to hold that value + 1.
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          tick;
    logic [3:0]    rows_m, rows_s;
    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_d;
    logic          valid_d, held_d;
    logic [3:0]    key_pat;

    keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_m <= ROWS_IDLE;
            rows_s <= ROWS_IDLE;
        end else begin
            rows_m <= row_n;
            rows_s <= rows_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SCAN;
            col_q     <= 2'd0;
            row_q     <= 2'd0;
            cnt_q     <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            key_code  <= code_d;
            key_valid <= valid_d;
            key_held  <= held_d;
        end
    end

    assign key_pat = ~(4'b0001 << row_q);
    assign col_n   = ~(4'b0001 << col_q);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        code_d  = key_code;
        valid_d = 1'b0;
        held_d  = key_held;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (single_low(rows_s)) begin
                        row_d   = low_index(rows_s);
                        cnt_d   = CNT_ONE;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (rows_s == key_pat) begin
                        if (cnt_q >= DEB_LAST) begin
                            code_d  = KEYMAP[{row_q, col_q}];
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = ST_SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
                ST_HELD: begin
                    if (rows_s == ROWS_IDLE) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (rows_s == ROWS_IDLE) begin
                        if (cnt_q >= DEB_LAST) begin
                            held_d  = 1'b0;
                            state_d = ST_SCAN;
                            col_d   = col_q + 2'd1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        // Any activity on the frozen column means the key is
                        // still (or again) down; no new press is reported.
                        state_d = ST_HELD;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0][3:0] keys = '0;   // keys[r][c] = 1 when pressed

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [3:0] last_code = 4'h0;

    keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key shorts its row to its column.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r][c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulses <= pulses + 1;
            last_code <= key_code;
        end
    end

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (key_valid !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_held_low(input int budget);
        int n = 0;
        while (key_held !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_col [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst_n = 1'b0;
        keys = '0;
        repeat (3) @(negedge clk);
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", col_n); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h expected 0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL idle_col0: got %b expected 1110", col_n); end
        for (int k = 0; k < 4; k++) begin
            repeat (8) @(negedge clk);
            checks++;
            if (col_n !== exp_col[k]) begin
                errors++; $display("FAIL idle_col_step%0d: got %b expected %b", k + 1, col_n, exp_col[k]);
            end
        end
        repeat (167) @(negedge clk);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", pulses); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL idle_code: got %h expected 0", key_code); end
    endtask

    task automatic test_single_key;
        int p0 = pulses;
        keys[1][2] = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL key6_pulses: got %0d expected 1", pulses - p0); end
        checks++; if (last_code !== 4'h6) begin errors++; $display("FAIL key6_code: got %h expected 6", last_code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL key6_held: got %b expected 1", key_held); end
        keys = '0;
        repeat (12) @(negedge clk);
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL key6_held_early: got %b expected 1", key_held); end
        wait_held_low(40);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL key6_release: got %b expected 0", key_held); end
        checks++; if (col_n !== 4'b0111) begin errors++; $display("FAIL key6_col_advance: got %b expected 0111", col_n); end
        repeat (8) @(negedge clk);
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL key6_scan_resume: got %b expected 1110", col_n); end
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL key6_pulses_after: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_bounce;
        int p0 = pulses;
        int cyc;
        int n = 0;
        logic [3:0] prev = col_n;
        @(negedge clk);
        while (!(col_n == 4'b1110 && prev != 4'b1110) && n < 64) begin
            prev = col_n;
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            keys[3][0] = (i % 2 == 0);
            repeat (8) @(negedge clk);
        end
        checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL bounce_no_pulse: got %0d expected 0", pulses - p0); end
        keys[3][0] = 1'b1;
        wait_valid(100, cyc);
        checks++; if (cyc !== 32) begin errors++; $display("FAIL bounce_latency: got %0d expected 32", cyc); end
        repeat (4) @(negedge clk);
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL bounce_pulses: got %0d expected 1", pulses - p0); end
        checks++; if (last_code !== 4'hE) begin errors++; $display("FAIL bounce_code: got %h expected e", last_code); end
        keys = '0;
        wait_held_low(60);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_release: got %b expected 0", key_held); end
    endtask

    task automatic test_multi_key;
        int p0 = pulses;
        int cyc;
        keys[0][3] = 1'b1;
        keys[2][3] = 1'b1;
        repeat (80) @(negedge clk);
        checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL multi_no_pulse: got %0d expected 0", pulses - p0); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_held: got %b expected 0", key_held); end
        keys[2][3] = 1'b0;
        wait_valid(80, cyc);
        repeat (4) @(negedge clk);
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL multi_pulses: got %0d expected 1", pulses - p0); end
        checks++; if (last_code !== 4'hA) begin errors++; $display("FAIL multi_code: got %h expected a", last_code); end
        keys = '0;
        wait_held_low(60);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_release: got %b expected 0", key_held); end
    endtask

    task automatic test_repress;
        int p0 = pulses;
        int cyc;
        int held_lows = 0;
        keys[1][1] = 1'b1;
        wait_valid(80, cyc);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL repress_first: got %b expected 1", key_valid); end
        keys = '0;
        repeat (8) @(negedge clk);
        keys[1][1] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (key_held !== 1'b1) held_lows++;
        end
        checks++; if (held_lows !== 0) begin errors++; $display("FAIL repress_held_drop: got %0d low cycles expected 0", held_lows); end
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL repress_pulses: got %0d expected 1", pulses - p0); end
        checks++; if (last_code !== 4'h5) begin errors++; $display("FAIL repress_code: got %h expected 5", last_code); end
        keys = '0;
        wait_held_low(60);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL repress_release: got %b expected 0", key_held); end
    endtask

    task automatic test_reset_mid;
        int p0;
        int cyc;
        keys[2][2] = 1'b1;
        wait_valid(80, cyc);
        repeat (10) @(negedge clk);
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rstmid_pre_held: got %b expected 1", key_held); end
        checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL rstmid_pre_code: got %h expected 9", key_code); end
        rst_n = 1'b0;
        #1;
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL rstmid_col: got %b expected 1110", col_n); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL rstmid_code: got %h expected 0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rstmid_held: got %b expected 0", key_held); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        wait_valid(100, cyc);
        checks++; if (cyc !== 40) begin errors++; $display("FAIL rstmid_latency: got %0d expected 40", cyc); end
        repeat (5) @(negedge clk);
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 1", pulses - p0); end
        checks++; if (last_code !== 4'h9) begin errors++; $display("FAIL rstmid_code_after: got %h expected 9", last_code); end
        keys = '0;
        wait_held_low(60);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rstmid_release: got %b expected 0", key_held); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_multi_key();
        test_repress();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
